j2_io_uart: RTL and testbench

- Memory-mapped UART that sits on the j2 core's I/O bus as the responder.
- It consumes the core's memory_address, data_out and io_write_enable, and drives the core's io_data_in.
- Provides 8N1 serial transmit/receive, status, and a programmable baud divisor for console and boot-loader traffic.
- Read data is registered, matching the core's synchronous-read timing: the address presented in cycle N yields data in cycle N+1.

---
 rtl/j2_io_pkg.sv | 37 +++
 rtl/j2_uart_rx.sv | 110 +++++++++++
 rtl/j2_io_uart.sv | 223 ++++++++++++++++++++++
 tb/tb_j2_io_uart.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j2_io_pkg.sv
// ---------------------------------------------------------------------------
// j2_io_pkg
// Shared definitions for the j2 I/O-bus UART: register offsets, STATUS bit
// positions, the 2-bit state encoding used by both serial FSMs, and the
// divisor clamp helper.
// ---------------------------------------------------------------------------
package j2_io_pkg;

   // Register offsets within the 16-byte decode window
   localparam logic [3:0] UART_TX_DATA = 4'h0;
   localparam logic [3:0] UART_RX_DATA = 4'h1;
   localparam logic [3:0] UART_STATUS  = 4'h2;
   localparam logic [3:0] UART_DIVISOR = 4'h3;

   // STATUS register bit positions
   localparam int STATUS_TX_BUSY       = 0;
   localparam int STATUS_RX_VALID      = 1;
   localparam int STATUS_RX_OVERRUN    = 2;
   localparam int STATUS_FRAMING_ERROR = 3;

   // Serial FSM states, shared by the transmitter and the receiver
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // The receiver waits divisor/2 - 1 cycles in START, so the divisor
   // must never drop below 2.
   localparam logic [15:0] MIN_DIVISOR = 16'd2;

   function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
      return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
   endfunction

endpackage

// File: rtl/j2_uart_rx.sv
// ---------------------------------------------------------------------------
// j2_uart_rx
// 8N1 serial receiver: 2-flop synchroniser, start-bit qualification,
// mid-bit sampling of 8 data bits (LSB first) and stop-bit check.
//
// Ports:
//   clock            system clock
//   active_low_reset asynchronous active-low reset
//   uart_rx          serial input, asynchronous to clock
//   divisor          clock cycles per serial bit (>= 2)
//   rx_byte          last assembled byte, valid when byte_strobe is high
//   byte_strobe      one-cycle pulse when a complete frame has been received
//   stop_error       high with byte_strobe when the stop bit sampled as 0
// ---------------------------------------------------------------------------
module j2_uart_rx
   import j2_io_pkg::*;
(
   input  logic        clock,
   input  logic        active_low_reset,
   input  logic        uart_rx,
   input  logic [15:0] divisor,
   output logic [7:0]  rx_byte,
   output logic        byte_strobe,
   output logic        stop_error
);

   logic        sync1_q;
   logic        sync2_q;
   uart_state_e state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [2:0]  bit_q,   bit_d;
   logic [7:0]  shift_q, shift_d;

   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= ST_IDLE;
         count_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
         state_q <= state_d;
         count_q <= count_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      byte_strobe = 1'b0;
      stop_error  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Half a bit to reach the middle of the start bit
            if (!sync2_q) begin
               state_d = ST_START;
               count_d = (divisor >> 1) - 16'd1;
            end
         end
         ST_START: begin
            if (count_q == 16'd0) begin
               // A line that is high again mid start bit was a glitch
               if (sync2_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  count_d = divisor - 16'd1;
                  bit_d   = 3'd0;
               end
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (count_q == 16'd0) begin
               shift_d = {sync2_q, shift_q[7:1]};
               count_d = divisor - 16'd1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (count_q == 16'd0) begin
               state_d     = ST_IDLE;
               byte_strobe = 1'b1;
               stop_error  = !sync2_q;
            end else begin
               count_d = count_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rx_byte = shift_q;

endmodule

// File: rtl/j2_io_uart.sv
// ---------------------------------------------------------------------------
// j2_io_uart
// Memory-mapped 8N1 UART responding on the j2 core I/O bus. Holds the
// transmitter FSM, the register file and the registered read mux; the
// receiver lives in j2_uart_rx.
//
// Ports:
//   clock            system clock
//   active_low_reset asynchronous active-low reset
//   io_address       bus address (core memory_address)
//   io_write_enable  bus write strobe (core io_write_enable)
//   io_write_data    bus write data (core data_out)
//   io_data_in       registered read data back to the core (1-cycle latency)
//   uart_rx          serial input
//   uart_tx          serial output, idles high
//   rx_irq           receive-data-available interrupt (mirrors rx_valid)
// ---------------------------------------------------------------------------
module j2_io_uart
   import j2_io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDRESS = 16'hF000,
   parameter int          CLKS_PER_BIT = 104,
   parameter int          WIDTH        = 16
) (
   input  logic             clock,
   input  logic             active_low_reset,
   input  logic [15:0]      io_address,
   input  logic             io_write_enable,
   input  logic [WIDTH-1:0] io_write_data,
   output logic [WIDTH-1:0] io_data_in,
   input  logic             uart_rx,
   output logic             uart_tx,
   output logic             rx_irq
);

   localparam logic [15:0] RESET_DIVISOR = 16'(CLKS_PER_BIT);

   logic       sel;
   logic [3:0] off;
   logic       wr;
   logic       unused_wdata;

   assign sel = (io_address[15:4] == BASE_ADDRESS[15:4]);
   assign off = io_address[3:0];
   assign wr  = io_write_enable && sel;

   // Only the low 16 bits of a wide bus are ever stored
   assign unused_wdata = ^io_write_data;

   // Register file
   logic [15:0]      divisor_q,       divisor_d;
   logic [7:0]       rx_data_q,       rx_data_d;
   logic             rx_valid_q,      rx_valid_d;
   logic             rx_overrun_q,    rx_overrun_d;
   logic             framing_error_q, framing_error_d;
   logic [WIDTH-1:0] io_data_in_q,    io_data_in_d;

   // Transmitter
   uart_state_e tx_state_q, tx_state_d;
   logic [15:0] tx_count_q, tx_count_d;
   logic [2:0]  tx_bit_q,   tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_q,       tx_d;
   logic        tx_busy;

   // Receiver interface
   logic [7:0] rx_byte;
   logic       byte_strobe;
   logic       stop_error;
   logic       rx_ack;

   j2_uart_rx u_rx (
      .clock            (clock),
      .active_low_reset (active_low_reset),
      .uart_rx          (uart_rx),
      .divisor          (divisor_q),
      .rx_byte          (rx_byte),
      .byte_strobe      (byte_strobe),
      .stop_error       (stop_error)
   );

   always_ff @(posedge clock or negedge active_low_reset) begin
      if (!active_low_reset) begin
         divisor_q       <= RESET_DIVISOR;
         rx_data_q       <= '0;
         rx_valid_q      <= 1'b0;
         rx_overrun_q    <= 1'b0;
         framing_error_q <= 1'b0;
         io_data_in_q    <= '0;
         tx_state_q      <= ST_IDLE;
         tx_count_q      <= '0;
         tx_bit_q        <= '0;
         tx_shift_q      <= '0;
         tx_q            <= 1'b1;
      end else begin
         divisor_q       <= divisor_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         rx_overrun_q    <= rx_overrun_d;
         framing_error_q <= framing_error_d;
         io_data_in_q    <= io_data_in_d;
         tx_state_q      <= tx_state_d;
         tx_count_q      <= tx_count_d;
         tx_bit_q        <= tx_bit_d;
         tx_shift_q      <= tx_shift_d;
         tx_q            <= tx_d;
      end
   end

   assign tx_busy = (tx_state_q != ST_IDLE);

   // Transmit FSM. The line level is registered from the next state so the
   // output is glitch-free and still drops high immediately on reset.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_count_d = tx_count_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = 1'b1;

      case (tx_state_q)
         ST_IDLE: begin
            if (wr && (off == UART_TX_DATA)) begin
               tx_state_d = ST_START;
               tx_count_d = divisor_q - 16'd1;
               tx_shift_d = io_write_data[7:0];
            end
         end
         ST_START: begin
            if (tx_count_q == 16'd0) begin
               tx_state_d = ST_DATA;
               tx_count_d = divisor_q - 16'd1;
               tx_bit_d   = 3'd0;
            end else begin
               tx_count_d = tx_count_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (tx_count_q == 16'd0) begin
               tx_count_d = divisor_q - 16'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = ST_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end else begin
               tx_count_d = tx_count_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (tx_count_q == 16'd0) begin
               tx_state_d = ST_IDLE;
            end else begin
               tx_count_d = tx_count_q - 16'd1;
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase

      case (tx_state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = tx_shift_d[tx_bit_d];
         default:  tx_d = 1'b1;
      endcase
   end

   assign rx_ack = wr && (off == UART_RX_DATA);

   // Register updates. Clears are applied first so that a simultaneous
   // receive event overrides them.
   always_comb begin
      divisor_d       = divisor_q;
      rx_data_d       = rx_data_q;
      rx_valid_d      = rx_valid_q;
      rx_overrun_d    = rx_overrun_q;
      framing_error_d = framing_error_q;

      if (wr && (off == UART_DIVISOR)) begin
         divisor_d = clamp_divisor(io_write_data[15:0]);
      end
      if (wr && (off == UART_STATUS)) begin
         if (io_write_data[STATUS_RX_OVERRUN])    rx_overrun_d    = 1'b0;
         if (io_write_data[STATUS_FRAMING_ERROR]) framing_error_d = 1'b0;
      end
      if (rx_ack) begin
         rx_valid_d = 1'b0;
      end

      if (byte_strobe) begin
         if (stop_error) framing_error_d = 1'b1;
         // An acknowledge in the same cycle frees the holding register
         if (!rx_valid_q || rx_ack) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
         end else begin
            rx_overrun_d = 1'b1;
         end
      end
   end

   // Registered read mux
   always_comb begin
      io_data_in_d = '0;
      if (sel) begin
         case (off)
            UART_RX_DATA: io_data_in_d[7:0] = rx_data_q;
            UART_STATUS: begin
               io_data_in_d[STATUS_TX_BUSY]       = tx_busy;
               io_data_in_d[STATUS_RX_VALID]      = rx_valid_q;
               io_data_in_d[STATUS_RX_OVERRUN]    = rx_overrun_q;
               io_data_in_d[STATUS_FRAMING_ERROR] = framing_error_q;
            end
            UART_DIVISOR: io_data_in_d[15:0] = divisor_q;
            default: io_data_in_d = '0;
         endcase
      end
   end

   assign io_data_in = io_data_in_q;
   assign uart_tx    = tx_q;
   assign rx_irq     = rx_valid_q;

endmodule

// File: tb/tb_j2_io_uart.sv
// ---------------------------------------------------------------------------
// tb_j2_io_uart
// Self-checking bench for j2_io_uart: register-map vector table, directed
// serial sequences, and randomized traffic against a behavioural model of
// the register state and of the 8N1 line format.
// ---------------------------------------------------------------------------
module tb_j2_io_uart;

   localparam int WIDTH = 16;

   logic             clock = 1'b0;
   logic             active_low_reset;
   logic [15:0]      io_address;
   logic             io_write_enable;
   logic [WIDTH-1:0] io_write_data;
   logic [WIDTH-1:0] io_data_in;
   logic             uart_rx;
   logic             uart_tx;
   logic             rx_irq;

   always #5 clock = ~clock;

   j2_io_uart #(
      .BASE_ADDRESS (16'hF000),
      .CLKS_PER_BIT (104),
      .WIDTH        (WIDTH)
   ) dut (
      .clock            (clock),
      .active_low_reset (active_low_reset),
      .io_address       (io_address),
      .io_write_enable  (io_write_enable),
      .io_write_data    (io_write_data),
      .io_data_in       (io_data_in),
      .uart_rx          (uart_rx),
      .uart_tx          (uart_tx),
      .rx_irq           (rx_irq)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model of the programmer-visible state
   int         m_div;
   logic [7:0] m_rx_data;
   bit         m_valid;
   bit         m_overrun;
   bit         m_ferr;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [15:0] m_status();
      logic [15:0] s;
      s = '0;
      s[1] = m_valid;
      s[2] = m_overrun;
      s[3] = m_ferr;
      return s;
   endfunction

   task automatic model_reset();
      m_div     = 104;
      m_rx_data = '0;
      m_valid   = 0;
      m_overrun = 0;
      m_ferr    = 0;
   endtask

   // All bus tasks start and end on a falling edge
   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      io_address      = a;
      io_write_data   = d;
      io_write_enable = 1'b1;
      @(negedge clock);
      io_write_enable = 1'b0;
      io_write_data   = '0;
   endtask

   task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
      bus_write(a, d);
      if (a[15:4] == 12'hF00) begin
         case (a[3:0])
            4'h1: m_valid = 0;
            4'h2: begin
               if (d[2]) m_overrun = 0;
               if (d[3]) m_ferr = 0;
            end
            4'h3: m_div = (d < 16'd2) ? 2 : int'(d);
            default: ;
         endcase
      end
   endtask

   task automatic expect_read(input string name, input logic [15:0] a, input logic [15:0] exp);
      io_address      = a;
      io_write_enable = 1'b0;
      @(negedge clock);
      check(name, io_data_in, exp);
   endtask

   // Drive one 8N1 frame, then let the receiver settle; update the model
   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int div);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = frame[i];
         repeat (div) @(negedge clock);
      end
      uart_rx = 1'b1;
      repeat (div + 6) @(negedge clock);
      if (!stop_bit) m_ferr = 1;
      if (!m_valid) begin
         m_rx_data = b;
         m_valid   = 1;
      end else begin
         m_overrun = 1;
      end
   endtask

   // Transmit a byte and compare every cycle of the line against the frame
   task automatic tx_frame(input logic [7:0] b, input string tag);
      logic [9:0] frame;
      int         div;
      frame = {1'b1, b, 1'b0};
      div   = m_div;
      bus_write(16'hF000, {8'h00, b});
      io_address = 16'hF002;
      for (int k = 0; k < 10 * div; k++) begin
         check({tag, "_line"}, uart_tx, frame[k / div]);
         if (k >= 1) check({tag, "_busy"}, io_data_in[0], 1'b1);
         @(negedge clock);
      end
      check({tag, "_idle_line"}, uart_tx, 1'b1);
      @(negedge clock);
      check({tag, "_idle_busy"}, io_data_in[0], 1'b0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got running, wanted finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frame55;
      logic [7:0] rb;
      bit         sb;
      int         op;
      logic [15:0] v;

      active_low_reset = 1'b0;
      io_address       = '0;
      io_write_enable  = 1'b0;
      io_write_data    = '0;
      uart_rx          = 1'b1;
      model_reset();

      repeat (3) @(negedge clock);
      check("reset_uart_tx", uart_tx, 1'b1);
      check("reset_io_data_in", io_data_in, '0);
      check("reset_rx_irq", rx_irq, 1'b0);
      active_low_reset = 1'b1;
      @(negedge clock);

      // ---------------- register-map vector table ----------------
      vecs.push_back('{1'b0, 16'hF002, 16'h0000, 16'h0000, "reset_status"});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'd104,  "reset_divisor"});
      vecs.push_back('{1'b0, 16'hF000, 16'h0000, 16'h0000, "tx_data_reads0"});
      vecs.push_back('{1'b0, 16'hF001, 16'h0000, 16'h0000, "reset_rx_data"});
      vecs.push_back('{1'b0, 16'hF004, 16'h0000, 16'h0000, "reserved_4"});
      vecs.push_back('{1'b0, 16'hF00F, 16'h0000, 16'h0000, "reserved_f"});
      vecs.push_back('{1'b0, 16'hE003, 16'h0000, 16'h0000, "unselected_read"});
      vecs.push_back('{1'b1, 16'hF003, 16'h0001, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'h0002, "div_clamp_1"});
      vecs.push_back('{1'b1, 16'hF003, 16'h0000, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'h0002, "div_clamp_0"});
      vecs.push_back('{1'b1, 16'hF003, 16'hABCD, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'hABCD, "div_full"});
      vecs.push_back('{1'b1, 16'hF005, 16'h1234, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'hABCD, "reserved_write_ignored"});
      vecs.push_back('{1'b0, 16'hF005, 16'h0000, 16'h0000, "reserved_reads0"});
      vecs.push_back('{1'b1, 16'h1003, 16'h0007, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'hABCD, "unselected_write_ignored"});
      vecs.push_back('{1'b1, 16'hF003, 16'h0002, 16'h0000, ""});
      vecs.push_back('{1'b0, 16'hF003, 16'h0000, 16'h0002, "div_min"});
      vecs.push_back('{1'b0, 16'hF002, 16'h0000, 16'h0000, "status_still_0"});

      foreach (vecs[i]) begin
         if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
         else            expect_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end

      // ---------------- directed receive sequences ----------------
      reg_write(16'hF003, 16'd4);
      send_frame(8'hA3, 1'b1, 4);
      check("a3_irq", rx_irq, 1'b1);
      expect_read("a3_status", 16'hF002, 16'h0002);
      expect_read("a3_data", 16'hF001, 16'h00A3);
      reg_write(16'hF001, 16'h0000);
      check("ack_irq", rx_irq, 1'b0);
      expect_read("ack_status", 16'hF002, 16'h0000);

      send_frame(8'h11, 1'b1, 4);
      send_frame(8'h22, 1'b1, 4);
      expect_read("overrun_data", 16'hF001, 16'h0011);
      expect_read("overrun_status", 16'hF002, 16'h0006);
      reg_write(16'hF002, 16'h0004);
      expect_read("overrun_cleared", 16'hF002, 16'h0002);
      reg_write(16'hF001, 16'h0000);

      send_frame(8'h7E, 1'b0, 4);
      expect_read("ferr_data", 16'hF001, 16'h007E);
      expect_read("ferr_status", 16'hF002, 16'h000A);
      reg_write(16'hF001, 16'h0000);
      reg_write(16'hF002, 16'h0008);
      expect_read("ferr_cleared", 16'hF002, 16'h0000);

      uart_rx = 1'b0;
      @(negedge clock);
      uart_rx = 1'b1;
      repeat (20) @(negedge clock);
      expect_read("glitch_status", 16'hF002, 16'h0000);
      check("glitch_irq", rx_irq, 1'b0);

      // ---------------- directed transmit with dropped write ----------------
      frame55 = {1'b1, 8'h55, 1'b0};
      io_address      = 16'hF000;
      io_write_data   = 16'h0055;
      io_write_enable = 1'b1;
      @(negedge clock);
      io_write_enable = 1'b0;
      io_address      = 16'hF002;
      for (int k = 0; k < 40; k++) begin
         check("tx55_line", uart_tx, frame55[k / 4]);
         if (k >= 1 && k != 11) check("tx55_busy", io_data_in[0], 1'b1);
         if (k == 10) begin
            io_address      = 16'hF000;
            io_write_data   = 16'h00AA;
            io_write_enable = 1'b1;
         end else begin
            io_address      = 16'hF002;
            io_write_enable = 1'b0;
         end
         @(negedge clock);
      end
      check("tx55_stop_done", uart_tx, 1'b1);
      @(negedge clock);
      check("tx55_not_busy", io_data_in[0], 1'b0);
      for (int k = 0; k < 8; k++) begin
         check("tx_drop_line_idle", uart_tx, 1'b1);
         @(negedge clock);
      end

      // ---------------- randomized traffic against the model ----------------
      for (int it = 0; it < 30; it++) begin
         op = $urandom_range(0, 3);
         case (op)
            0: begin
               v = 16'($urandom_range(0, 6));
               reg_write(16'hF003, v);
               expect_read("rnd_divisor", 16'hF003, 16'(m_div));
            end
            1: begin
               rb = 8'($urandom_range(0, 255));
               sb = ($urandom_range(0, 3) != 0);
               send_frame(rb, sb, m_div);
               check("rnd_irq", rx_irq, m_valid);
               expect_read("rnd_status", 16'hF002, m_status());
               expect_read("rnd_rx_data", 16'hF001, {8'h00, m_rx_data});
            end
            2: begin
               rb = 8'($urandom_range(0, 255));
               tx_frame(rb, "rnd_tx");
            end
            default: begin
               v = 16'($urandom_range(0, 15));
               reg_write(($urandom_range(0, 1) != 0) ? 16'hF001 : 16'hF002, v);
               expect_read("rnd_clear_status", 16'hF002, m_status());
            end
         endcase
      end

      // ---------------- reset in the middle of a transmit ----------------
      reg_write(16'hF003, 16'd4);
      send_frame(8'h5A, 1'b1, 4);
      bus_write(16'hF000, 16'h0055);
      @(negedge clock);
      check("pre_reset_start_bit", uart_tx, 1'b0);
      active_low_reset = 1'b0;
      #1;
      check("reset_mid_tx_line", uart_tx, 1'b1);
      check("reset_mid_tx_irq", rx_irq, 1'b0);
      check("reset_mid_tx_rdata", io_data_in, '0);
      @(negedge clock);
      active_low_reset = 1'b1;
      model_reset();
      expect_read("post_reset_status", 16'hF002, 16'h0000);
      expect_read("post_reset_divisor", 16'hF003, 16'd104);
      check("post_reset_line", uart_tx, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
